// File: rtl/fsm_word_serializer_if.sv
// Handshake bundle for fsm_word_serializer.
//   Upstream word side : in_data, in_valid (to block), in_ready (from block)
//   Downstream bit side: x, x_valid, x_first, x_last (from block), x_ready (to block)
//   Status             : busy (from block)
// The slave modport is the serializer's view; master is the view of whatever
// drives it (upstream producer plus downstream consumer).
interface fsm_word_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             x;
  logic             x_valid;
  logic             x_first;
  logic             x_last;
  logic             x_ready;
  logic             busy;

  modport slave (
    input  in_data, in_valid, x_ready,
    output in_ready, x, x_valid, x_first, x_last, busy
  );

  modport master (
    output in_data, in_valid, x_ready,
    input  in_ready, x, x_valid, x_first, x_last, busy
  );
endinterface

// File: rtl/fsm_word_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word over valid/ready and
// emits it LSB first, one bit per x_valid && x_ready transfer, framed with
// x_first / x_last.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - fsm_word_serializer_if.slave (word input, serial output, busy)
module fsm_word_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fsm_word_serializer_if.slave   bus
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;

  logic on_last;
  logic xfer;
  logic accept;

  assign on_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign xfer    = (state_q == SHIFT) && bus.x_ready;

  // Ready is combinational from x_ready so a new word can be taken on the
  // same edge the previous word's last bit leaves (no bubble). Gated by
  // rst_n so nothing is accepted while reset is asserted.
  assign bus.in_ready = rst_n && ((state_q == IDLE) || (on_last && bus.x_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sreg_q  <= bus.in_data;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (on_last) begin
              if (accept) begin
                sreg_q <= bus.in_data;
                cnt_q  <= '0;
              end else begin
                sreg_q  <= '0;
                cnt_q   <= '0;
                state_q <= IDLE;
              end
            end else begin
              sreg_q <= sreg_q >> 1;
              cnt_q  <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state only (no input paths).
  assign bus.busy    = (state_q == SHIFT);
  assign bus.x_valid = (state_q == SHIFT);
  assign bus.x       = (state_q == SHIFT) && sreg_q[0];
  assign bus.x_first = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.x_last  = on_last;

endmodule

// File: tb/tb_fsm_word_serializer.sv
module tb_fsm_word_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_word_serializer_if #(.WIDTH(8)) if8 ();
  fsm_word_serializer_if #(.WIDTH(2)) if2 ();

  fsm_word_serializer #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  fsm_word_serializer #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int tests_run = 0;
  int tests_failed = 0;

  // Transaction-level reference: the word currently being sent and how many
  // of its bits have already left. Emitted bits are logged in m_out.
  logic [7:0] m_word = '0;
  int         m_pos = 0;
  bit         m_busy = 1'b0;
  int         m_accepts = 0;
  bit         m_out[$];

  // Vector order: {x_valid, x, x_first, x_last, in_ready, busy}
  task automatic cyc8(input logic v, input logic [7:0] d, input logic r,
                      output logic [5:0] act, output logic [5:0] exp);
    logic acc, xf;
    if8.in_valid = v;
    if8.in_data  = d;
    if8.x_ready  = r;
    #1;
    act = {if8.x_valid, if8.x, if8.x_first, if8.x_last, if8.in_ready, if8.busy};
    if (!m_busy) exp = 6'b000010;
    else exp = {1'b1, m_word[m_pos], 1'(m_pos == 0), 1'(m_pos == 7),
                1'((m_pos == 7) && r), 1'b1};
    if (!rst_n) exp[1] = 1'b0;
    acc = rst_n && v && exp[1];
    xf  = rst_n && m_busy && r;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_pos  = 0;
    end else begin
      if (xf) begin
        m_out.push_back(m_word[m_pos]);
        m_pos++;
        if (m_pos == 8) m_busy = 1'b0;
      end
      if (acc) begin
        m_word = d;
        m_pos  = 0;
        m_busy = 1'b1;
        m_accepts++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Vector order: {x_valid, x, x_first, x_last, in_ready}
  task automatic cyc2(input logic v, input logic [1:0] d, input logic r,
                      output logic [4:0] act);
    if2.in_valid = v;
    if2.in_data  = d;
    if2.x_ready  = r;
    #1;
    act = {if2.x_valid, if2.x, if2.x_first, if2.x_last, if2.in_ready};
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] out_word(input int start);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[i] = m_out[start + i];
    return w;
  endfunction

  task automatic test_reset();
    logic [5:0] a, e;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc8(1'($urandom_range(1)), 8'($urandom), 1'b1, a, e);
      tests_run++;
      if (a !== e || a !== 6'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: got %b expected %b", i, a, 6'b0);
      end
    end
    rst_n = 1'b1;
    cyc8(1'b0, 8'h00, 1'b1, a, e);
    tests_run++;
    if (a !== 6'b000010) begin
      tests_failed++;
      $display("FAIL reset_release: got %b expected %b", a, 6'b000010);
    end
  endtask

  task automatic test_single_word();
    logic [5:0] a, e;
    int nvalid;
    m_out.delete();
    nvalid = 0;
    cyc8(1'b1, 8'hB4, 1'b1, a, e);
    for (int i = 0; i < 9; i++) begin
      cyc8(1'b0, 8'h00, 1'b1, a, e);
      if (a[5]) nvalid++;
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL single_word cyc%0d: got %b expected %b", i + 1, a, e);
      end
    end
    tests_run++;
    if (m_out.size() != 8 || nvalid != 8 || out_word(0) !== 8'hB4) begin
      tests_failed++;
      $display("FAIL single_word_seq: got %0d bits valid=%0d word %h expected 8 bits b4", m_out.size(), nvalid, out_word(0));
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] a, e;
    int nvalid, acc0;
    m_out.delete();
    nvalid = 0;
    acc0 = m_accepts;
    cyc8(1'b1, 8'h01, 1'b1, a, e);
    for (int i = 0; i < 17; i++) begin
      cyc8(i < 8, 8'h80, 1'b1, a, e);
      if (a[5]) nvalid++;
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", i + 1, a, e);
      end
      if (i == 7) begin
        tests_run++;
        if (a[2] !== 1'b1 || a[1] !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_accept_on_last: last=%b in_ready=%b expected 1 1", a[2], a[1]);
        end
      end
    end
    tests_run++;
    if (nvalid != 16 || m_accepts - acc0 != 2 || m_out.size() != 16 ||
        out_word(0) !== 8'h01 || out_word(8) !== 8'h80) begin
      tests_failed++;
      $display("FAIL b2b_seq: valid=%0d accepts=%0d expected 16 2", nvalid, m_accepts - acc0);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] a, e;
    int ncyc;
    m_out.delete();
    ncyc = 0;
    cyc8(1'b1, 8'hF0, 1'b1, a, e);
    for (int i = 0; i < 3; i++) begin
      cyc8(1'b0, 8'h00, 1'b1, a, e);
      ncyc++;
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL bp_lead cyc%0d: got %b expected %b", i, a, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc8(1'b1, 8'($urandom), 1'b0, a, e);
      ncyc++;
      tests_run++;
      if (a !== e || a !== 6'b100001) begin
        tests_failed++;
        $display("FAIL bp_hold cyc%0d: got %b expected %b", i, a, 6'b100001);
      end
    end
    while (a[5] && ncyc < 20) begin
      cyc8(1'b0, 8'h00, 1'b1, a, e);
      ncyc++;
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL bp_tail cyc%0d: got %b expected %b", ncyc, a, e);
      end
    end
    // ncyc counts the first idle cycle too: 8 bits + 3 stalls + 1
    tests_run++;
    if (ncyc != 12 || m_out.size() != 8 || out_word(0) !== 8'hF0) begin
      tests_failed++;
      $display("FAIL bp_seq: cycles %0d word %h expected 12 f0", ncyc, out_word(0));
    end
  endtask

  task automatic test_input_held_off();
    logic [5:0] a, e;
    logic [7:0] d;
    int acc0, nready;
    m_out.delete();
    acc0 = m_accepts;
    nready = 0;
    d = '0;
    cyc8(1'b1, 8'hA3, 1'b1, a, e);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      cyc8(1'b1, d, 1'b1, a, e);
      if (a[1]) nready++;
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL held_off cyc%0d: got %b expected %b", i, a, e);
      end
    end
    for (int i = 0; i < 9; i++) begin
      cyc8(1'b0, 8'($urandom), 1'b1, a, e);
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL held_off_drain cyc%0d: got %b expected %b", i, a, e);
      end
    end
    tests_run++;
    if (nready != 1 || m_accepts - acc0 != 2 || out_word(0) !== 8'hA3 || out_word(8) !== d) begin
      tests_failed++;
      $display("FAIL held_off_seq: ready=%0d word2 %h expected 1 %h", nready, out_word(8), d);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [5:0] a, e;
    m_out.delete();
    cyc8(1'b1, 8'hAA, 1'b1, a, e);
    for (int i = 0; i < 4; i++) cyc8(1'b0, 8'h00, 1'b1, a, e);
    rst_n = 1'b0;
    cyc8(1'b1, 8'h55, 1'b1, a, e);
    tests_run++;
    if (a !== e || a[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_during: got %b expected %b", a, e);
    end
    rst_n = 1'b1;
    cyc8(1'b1, 8'h55, 1'b1, a, e);
    tests_run++;
    if (a !== 6'b000010) begin
      tests_failed++;
      $display("FAIL rst_mid_after: got %b expected %b", a, 6'b000010);
    end
    for (int i = 0; i < 9; i++) begin
      cyc8(1'b0, 8'h00, 1'b1, a, e);
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL rst_mid_new cyc%0d: got %b expected %b", i, a, e);
      end
    end
    tests_run++;
    if (m_out.size() != 12 || out_word(4) !== 8'h55) begin
      tests_failed++;
      $display("FAIL rst_mid_seq: bits %0d word %h expected 12 55", m_out.size(), out_word(4));
    end
  endtask

  task automatic test_random();
    logic [5:0] a, e;
    for (int i = 0; i < 400; i++) begin
      cyc8(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(3) != 0), a, e);
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL random cyc%0d: got %b expected %b", i, a, e);
      end
    end
  endtask

  task automatic test_width2();
    logic [4:0] a;
    logic [4:0] exp2 [0:5];
    exp2[0] = 5'b00001;
    exp2[1] = 5'b10100;
    exp2[2] = 5'b11011;
    exp2[3] = 5'b11100;
    exp2[4] = 5'b10011;
    exp2[5] = 5'b00001;
    cyc2(1'b1, 2'b10, 1'b1, a);
    tests_run++;
    if (a !== exp2[0]) begin
      tests_failed++;
      $display("FAIL w2 cyc0: got %b expected %b", a, exp2[0]);
    end
    for (int i = 1; i < 6; i++) begin
      cyc2(i < 3, 2'b01, 1'b1, a);
      tests_run++;
      if (a !== exp2[i]) begin
        tests_failed++;
        $display("FAIL w2 cyc%0d: got %b expected %b", i, a, exp2[i]);
      end
    end
  endtask

  initial begin
    if8.in_valid = 1'b0; if8.in_data = '0; if8.x_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.x_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_input_held_off();
    test_reset_mid_word();
    test_random();
    test_width2();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fsm_word_serializer.md
# fsm_word_serializer

Parallel-to-serial front end for the bit-serial FSM stages in `fsm_warmup`. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per transfer, LSB first. The LSB-first order is the order required by the serial two's-complement copy/invert stage. Each word is framed with `x_first` and `x_last` so the downstream FSM can restart its state per word.

## Interface
- `WIDTH`, default 8: word width in bits; legal range ≥ 2.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_data`  in  WIDTH: parallel word. Sampled when `in_valid && in_ready`.
- `in_valid`  in  1: upstream word available.
- `in_ready`  out  1: block can accept a word this cycle.
- `x`  out  1: current serial bit.
- `x_valid`  out  1: `x` is meaningful.
- `x_first`  out  1: `x` is bit 0 of a word.
- `x_last`  out  1: `x` is bit WIDTH-1 of a word.
- `x_ready`  in  1: downstream accepts `x` this cycle.
- `busy`  out  1: a word is in flight (state is SHIFT).

## Operation
- State machine: IDLE, SHIFT. Internal state:
  - `sreg[WIDTH-1:0]`: shift register.
  - `cnt`: bit counter, width `$clog2(WIDTH)`.
- A bit transfer occurs when `x_valid && x_ready`.
- Accept occurs when `in_valid && in_ready`.
- Accept loads `sreg <= in_data`, `cnt <= 0`, and `state <= SHIFT`.
- Outputs in IDLE:
  - `x_valid = 0`, `x = 0`, `x_first = 0`, `x_last = 0`, `busy = 0`.
  - `in_ready = 1`.
- Outputs in SHIFT:
  - `x_valid = 1`, `x = sreg[0]`, `busy = 1`.
  - `x_first = (cnt == 0)`, `x_last = (cnt == WIDTH-1)`.
- On a non-last transfer: `sreg` shifts right (zero fill) and `cnt` increments.
- On a last transfer (`x_last`):
  - If an accept also occurs in that cycle: load the new word and stay in SHIFT with `cnt = 0`.
  - Otherwise: go to IDLE.
- `in_ready = (state == IDLE) || (state == SHIFT && x_last && x_ready)`.
  - This path is combinational from `x_ready`.
  - Downstream must not derive `x_ready` from `in_ready`.
- Without a transfer (`x_ready = 0` in SHIFT), all outputs and internal state hold unchanged.
- `in_data` is never sampled outside an accept. Changes to `in_data` while the block is busy have no effect.
- `x_valid` must not drop while in SHIFT. Once a word starts, all WIDTH bits are presented contiguously subject only to `x_ready`.

## Timing
- Reset, on any edge where `rst_n = 0`:
  - `state = IDLE`, `sreg = 0`, `cnt = 0`.
  - Every output is 0, including `in_ready`. `in_ready` is forced 0 while `rst_n` is low.
- Reset mid-word: the in-flight word is discarded with no partial completion.
  - `x_valid = 0` in the first cycle after the reset edge.
  - `in_ready = 1` in the first cycle with `rst_n` high.
- Latency: a word accepted at edge N presents bit 0 in the cycle after edge N, with `x_first = 1`.
- With `x_ready` held at 1, the word's bits occupy WIDTH consecutive cycles.
- Throughput: back-to-back words with `in_valid` and `x_ready` held high give one bit per cycle with no bubble. The next word's bit 0 immediately follows the previous word's bit WIDTH-1.
- `x_first` and `x_last` are never both 1 (WIDTH ≥ 2).
- Counter wrap: `cnt` never exceeds WIDTH-1. It resets to 0 on every load.
- Simultaneous last transfer and accept is legal and required (see Operation).
- No accept is possible in SHIFT except on the last-bit transfer cycle.

## Test plan
- Single word: WIDTH=8, `in_data = 8'hB4`, `x_ready = 1`.
  - Required: `x` = 0,0,1,0,1,1,0,1 over cycles 1–8.
  - `x_first` in cycle 1 only, `x_last` in cycle 8 only.
  - IDLE with `in_ready = 1` in cycle 9.
- Back-to-back: `8'h01` then `8'h80`, `in_valid` held high.
  - Required: 16 consecutive `x_valid` cycles.
  - `x` = 1,0×7, then 0×7,1.
  - Second accept coincides with the first word's `x_last` transfer.
- Backpressure: `x_ready = 0` for 3 cycles while bit 3 of `8'hF0` is presented.
  - Required: `x = 0`, `x_valid = 1`, and `cnt` all hold for 3 cycles.
  - Word completes 3 cycles late with the correct bit sequence.
- Input held off: second word offered with `in_valid = 1` while busy.
  - Required: `in_ready = 0` until the `x_last && x_ready` cycle.
  - Word accepted there exactly once; `in_data` changes before that point are ignored.
- Reset mid-word: `rst_n = 0` for one edge during bit 4 of `8'hAA`.
  - Required: all outputs 0 after that edge.
  - No further bits of `8'hAA` are emitted.
  - A new word `8'h55` is accepted and serialized normally.
- WIDTH=2 corner: words `2'b10`, `2'b01` back-to-back.
  - Required: `x` = 0,1,1,0.
  - `x_first` and `x_last` alternate each cycle.
